alu_exec_cluster: RTL
=====================

// Module: alu_exec_cluster
// PURPOSE
//  Parametrised integer execute cluster: NUM_LANES independent ALU lanes, each taking one issued
//  reservation-station entry and returning {result, ROB tag} to the CDB arbiter.
//  Adds per-lane valid/ready handshake, output hold under CDB back-pressure, flush, wider RV32I ALU op set
//  and optional multi-cycle multiply. Sits between issue-select and CDB/ROB writeback.
// PARAMETERS
//  NUM_LANES  2   number of parallel ALU lanes
//  XLEN       32  operand/result width
//  TAG_W      6   ROB tag width
//  MUL_LAT    3   multiply latency in cycles, >=2 (used only with ALU_MUL_EN)
// PORTS
//  clk         in   1                clock, all state on rising edge
//  rst_n       in   1                asynchronous active-low reset
//  flush       in   1                kill all in-flight work (mispredict/exception)
//  in_valid    in   NUM_LANES        lane issues an entry this cycle
//  in_ready    out  NUM_LANES        lane accepts the entry this cycle
//  in_opcode   in   NUM_LANES*7      RISC-V opcode per lane
//  in_funct3   in   NUM_LANES*3      funct3 per lane
//  in_funct7   in   NUM_LANES*7      funct7 per lane
//  in_src1     in   NUM_LANES*XLEN   rs1 value
//  in_src2     in   NUM_LANES*XLEN   rs2 value
//  in_imm      in   NUM_LANES*XLEN   sign-extended immediate (U-type: raw 20-bit field in low bits)
//  in_tag      in   NUM_LANES*TAG_W  ROB tag
//  out_valid   out  NUM_LANES        result held for CDB
//  out_ready   in   NUM_LANES        CDB grant; result consumed when valid & ready
//  out_result  out  NUM_LANES*XLEN   result
//  out_tag     out  NUM_LANES*TAG_W  ROB tag of result
//  out_illegal out  NUM_LANES        op not supported by this cluster
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, out_tag=0, out_illegal=0, lane FSM=IDLE, in_ready=1.
//  Lane FSM: IDLE | HOLD | MBUSY (MBUSY only with ALU_MUL_EN).
//  Accept = in_valid & in_ready. in_ready = (IDLE) | (HOLD & out_ready); 0 in MBUSY.
//  Single-cycle ops: accepted in cycle N -> out_valid=1 in N+1, state HOLD. Latency 1, throughput 1/cycle
//   while out_ready=1. HOLD & ~out_ready: outputs frozen, in_ready=0. HOLD & out_ready & no accept -> IDLE.
//  Ops: OP(0110011): add/sub(funct7[5]), sll, slt, sltu, xor, srl/sra(funct7[5]), or, and.
//   OP-IMM(0010011): addi, slti, sltiu, xori, ori, andi, slli, srli/srai(imm[10]).
//   LUI(0110111): result = imm<<12 truncated to XLEN.
//  Shift amount = low $clog2(XLEN) bits of src2/imm. sra/srai arithmetic on signed src1. All add/sub wrap mod 2^XLEN.
//  Unsupported opcode/funct: out_valid=1, out_result=0, out_illegal=1 (ROB raises the exception).
//  flush: next edge out_valid=0, FSM=IDLE, any multiply abandoned; entry presented same cycle is dropped.
//  Reset mid-operation: immediate return to reset values, no partial result emitted.
//  Lanes are fully independent; no cross-lane ordering.
// CONFIGURATION
//  ALU_MUL_EN defined: OP with funct7=0000001, funct3=000 (mul, low XLEN bits) accepted; lane enters MBUSY,
//   down-counter loaded MUL_LAT-1; out_valid rises exactly MUL_LAT cycles after accept, then HOLD.
//   mulh/mulhsu/mulhu/div* remain illegal.
//  ALU_MUL_EN undefined: all funct7=0000001 ops are illegal (latency 1, out_illegal=1); no MBUSY state/counter.
// STRUCTURE
//  alu_pkg: opcode/funct3/funct7 constants, FSM state encoding, illegal-op decode function.
//  Sub-module alu_lane (one lane: decode, datapath, FSM, output register); top instantiates NUM_LANES via generate
//  and slices flattened buses.
// TESTING
//  1 lane0 add src1=5,src2=7,tag=3 -> next cycle out_valid=1, result=12, tag=3; sub 5-7 -> 0xFFFFFFFE.
//  2 srai src1=0x80000000 imm=4 -> 0xF8000000; srli same -> 0x08000000; sltu 1,0xFFFFFFFF -> 1; lui imm=0x12345 -> 0x12345000.
//  3 out_ready=0 for 3 cycles with result held -> result/tag stable, in_ready=0; out_ready=1 -> consumed, next op accepted same cycle.
//  4 both lanes issue simultaneously (xor 0xF0^0xFF, ori 0x0F|0x30) -> independent results 0x0F and 0x3F, correct tags.
//  5 flush while out_valid=1 and new in_valid=1 -> next cycle out_valid=0, new entry dropped; rst_n low mid-HOLD -> outputs 0 asynchronously.
//  6 mul 6*7 with ALU_MUL_EN, MUL_LAT=3 -> out_valid exactly 3 cycles after accept, result 42, in_ready=0 meanwhile;
//    without macro -> 1 cycle, out_illegal=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute cluster: opcode and funct encodings, lane FSM
// state type, and the legality decode used by every lane.
// Optional feature: define ALU_MUL_EN to enable the multi-cycle multiply (mul only).
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StHold, StMbusy} lane_state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold} lane_state_e;
`endif

  // True for the only M-extension op this cluster executes.
  function automatic logic is_mul(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic [6:0] funct7);
`ifdef ALU_MUL_EN
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV) && (funct3 == F3_ADD);
`else
    return 1'b0 & (|{opcode, funct3, funct7});
`endif
  endfunction

  // imm_hi is imm[11:5]; for OP-IMM shifts it plays the role of funct7.
  function automatic logic is_illegal(input logic [6:0] opcode, input logic [2:0] funct3,
                                      input logic [6:0] funct7, input logic [6:0] imm_hi);
    logic ill;
    ill = 1'b1;
    if (opcode == OPC_LUI) begin
      ill = 1'b0;
    end else if (opcode == OPC_OP) begin
      if (funct7 == F7_BASE) begin
        ill = 1'b0;
      end else if (funct7 == F7_ALT) begin
        ill = !((funct3 == F3_ADD) || (funct3 == F3_SR));
      end else begin
        ill = !is_mul(opcode, funct3, funct7);
      end
    end else if (opcode == OPC_OP_IMM) begin
      if (funct3 == F3_SLL) begin
        ill = (imm_hi != F7_BASE);
      end else if (funct3 == F3_SR) begin
        ill = !((imm_hi == F7_BASE) || (imm_hi == F7_ALT));
      end else begin
        ill = 1'b0;
      end
    end
    return ill;
  endfunction

endpackage

// File: rtl/alu_lane.sv
// One execute lane: decode, single-cycle ALU datapath, handshake FSM and output register.
// With ALU_MUL_EN defined, mul is held in an MBUSY state for MUL_LAT cycles before release.
module alu_lane
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  if (MUL_LAT < 2) begin : g_lat_check
    $error("MUL_LAT must be at least 2");
  end

  lane_state_e      state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;

  logic [XLEN-1:0]  op2;
  logic [ShW-1:0]   shamt;
  logic             alt;
  logic             illegal;
  logic             mul_op;
  logic [XLEN-1:0]  sra_res;
  logic [XLEN-1:0]  alu_res;
  logic             in_ready;
  logic             accept;

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = $clog2(MUL_LAT);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Decode and single-cycle datapath; illegal ops produce a zero result.
  always_comb begin
    op2     = (opcode_i == OPC_OP) ? src2_i : imm_i;
    shamt   = op2[ShW-1:0];
    alt     = (opcode_i == OPC_OP) ? funct7_i[5] : imm_i[10];
    illegal = is_illegal(opcode_i, funct3_i, funct7_i, imm_i[11:5]);
    mul_op  = is_mul(opcode_i, funct3_i, funct7_i);
    sra_res = $signed(src1_i) >>> shamt;
    alu_res = '0;
    if (illegal) begin
      alu_res = '0;
    end else if (opcode_i == OPC_LUI) begin
      alu_res = imm_i << 12;
`ifdef ALU_MUL_EN
    end else if (mul_op) begin
      alu_res = src1_i * src2_i;
`endif
    end else begin
      case (funct3_i)
        F3_ADD:  alu_res = (opcode_i == OPC_OP && alt) ? src1_i - op2 : src1_i + op2;
        F3_SLL:  alu_res = src1_i << shamt;
        F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(op2))};
        F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1_i < op2)};
        F3_XOR:  alu_res = src1_i ^ op2;
        F3_SR:   alu_res = alt ? sra_res : (src1_i >> shamt);
        F3_OR:   alu_res = src1_i | op2;
        F3_AND:  alu_res = src1_i & op2;
        default: alu_res = '0;
      endcase
    end
  end

  // Handshake FSM: next state, captured result and ready.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    tag_d     = tag_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
`ifdef ALU_MUL_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StHold:  in_ready = out_ready_i;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid_i & in_ready;

    if (flush_i) begin
      state_d = StIdle;
`ifdef ALU_MUL_EN
      cnt_d   = '0;
`endif
    end else if (accept) begin
      result_d  = alu_res;
      tag_d     = tag_i;
      illegal_d = illegal;
      state_d   = StHold;
`ifdef ALU_MUL_EN
      if (mul_op) begin
        state_d = StMbusy;
        cnt_d   = CntW'(MUL_LAT - 1);
      end
`endif
    end else begin
      case (state_q)
        StHold: if (out_ready_i) state_d = StIdle;
`ifdef ALU_MUL_EN
        StMbusy: begin
          if (cnt_q == CntW'(1)) state_d = StHold;
          else cnt_d = CntW'(cnt_q - 1'b1);
        end
`endif
        default: state_d = state_q;
      endcase
    end
    out_valid_d = (state_d == StHold);
  end

  // Lane state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign tag_o       = tag_q;
  assign illegal_o   = illegal_q;

endmodule

// File: rtl/alu_exec_cluster.sv
// Integer execute cluster: NUM_LANES independent ALU lanes between issue-select and the CDB.
// Optional feature: define ALU_MUL_EN to enable the multi-cycle multiply (mul only).
module alu_exec_cluster
  import alu_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_LANES-1:0]       in_valid,
  output logic [NUM_LANES-1:0]       in_ready,
  input  logic [NUM_LANES*7-1:0]     in_opcode,
  input  logic [NUM_LANES*3-1:0]     in_funct3,
  input  logic [NUM_LANES*7-1:0]     in_funct7,
  input  logic [NUM_LANES*XLEN-1:0]  in_src1,
  input  logic [NUM_LANES*XLEN-1:0]  in_src2,
  input  logic [NUM_LANES*XLEN-1:0]  in_imm,
  input  logic [NUM_LANES*TAG_W-1:0] in_tag,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*XLEN-1:0]  out_result,
  output logic [NUM_LANES*TAG_W-1:0] out_tag,
  output logic [NUM_LANES-1:0]       out_illegal
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    alu_lane #(
      .XLEN    (XLEN),
      .TAG_W   (TAG_W),
      .MUL_LAT (MUL_LAT)
    ) u_lane (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid[l]),
      .in_ready_o  (in_ready[l]),
      .opcode_i    (in_opcode[l*7 +: 7]),
      .funct3_i    (in_funct3[l*3 +: 3]),
      .funct7_i    (in_funct7[l*7 +: 7]),
      .src1_i      (in_src1[l*XLEN +: XLEN]),
      .src2_i      (in_src2[l*XLEN +: XLEN]),
      .imm_i       (in_imm[l*XLEN +: XLEN]),
      .tag_i       (in_tag[l*TAG_W +: TAG_W]),
      .out_valid_o (out_valid[l]),
      .out_ready_i (out_ready[l]),
      .result_o    (out_result[l*XLEN +: XLEN]),
      .tag_o       (out_tag[l*TAG_W +: TAG_W]),
      .illegal_o   (out_illegal[l])
    );
  end

endmodule
